fx2_slave_fifo_model: RTL and testbench
=======================================

// Module: fx2_slave_fifo_model
// PURPOSE
//  Synthesizable model of the Cypress FX2 slave-FIFO side of the high-speed link: the
//  device the FPGA's hs_io master talks to. Buffers host->FPGA words (EP2 OUT) and serves
//  them to SLRD; accepts FPGA->host words (EP6 IN) on SLWR and packetizes them on size or PKTEND.
//  Used for on-chip loopback self-test and as the bench partner of the high-speed I/O path.
// PARAMETERS
//  OUT_AW     9    log2 depth of the EP2 buffer, 16-bit words (512 words)
//  IN_AW      9    log2 depth of the EP6 buffer, 18-bit entries (512 entries)
//  PKT_WORDS  256  EP6 auto-commit size in words (512-byte USB packet)
// PORTS
//  IFCLK         in   1   single clock; all logic rising-edge
//  RESET         in   1   asynchronous, active-high
//  FIFOADR       in   2   endpoint select: 2'b00=EP2, 2'b10=EP6; 01/11 unsupported
//  SLOE          in   1   active-low output enable for fifo_dout
//  SLRD          in   1   active-low read strobe (pops EP2)
//  SLWR          in   1   active-low write strobe (pushes fifo_din into EP6)
//  PKTEND        in   1   active-low commit of a short/zero-length EP6 packet
//  fifo_din      in   16  data written by FPGA
//  fifo_dout     out  16  EP2 head word
//  fifo_doe      out  1   bus drive enable = !SLOE && FIFOADR==EP2
//  FLAGB         out  1   active-low EP6 FULL
//  FLAGC         out  1   active-low EP2 EMPTY
//  host_din      in   16  host-side EP2 fill data
//  host_wr       in   1   push host_din into EP2 (ignored when host_full)
//  host_full     out  1   EP2 full
//  host_dout     out  16  EP6 head data (first-word fall-through)
//  host_last     out  1   head entry ends a packet
//  host_zlp      out  1   head entry is a zero-length-packet marker (host_dout=0)
//  host_empty    out  1   no committed EP6 entry available
//  host_rd       in   1   pop EP6 head (ignored when host_empty)
//  err           out  3   sticky {addr, underflow, overflow}; cleared only by RESET
// BEHAVIOUR
//  - Reset: both buffers empty, word counter 0; FLAGB=1, FLAGC=0 (empty), host_full=0,
//    host_empty=1, host_last=0, host_zlp=0, err=0, fifo_doe per inputs, fifo_dout=0.
//  - EP2 read: fifo_dout shows head word combinationally from FWFT buffer. SLRD=0 with
//    FIFOADR=EP2 at an edge pops; next word visible one cycle later. Pop while empty: no
//    pop, err[1] set, fifo_dout holds last value.
//  - FLAGC registered: reflects EP2 emptiness one cycle after the causing edge. Master
//    may read once while stale; that read is the underflow case above.
//  - EP6 write: SLWR=0 with FIFOADR=EP6 stores {last,zlp=0,data}. Word counter increments;
//    when it reaches PKT_WORDS the entry is stored with last=1 and counter clears.
//  - PKTEND=0 with FIFOADR=EP6: counter>0 -> previous stored entry's last set (via a
//    pending-last register, never rewriting RAM: last word held in staging reg until
//    next write/commit); counter==0 -> push ZLP entry {1,1,16'h0}. Counter clears.
//  - SLWR and PKTEND in same cycle: word stored with last=1 (one commit, no ZLP).
//  - Committed visibility: an EP6 entry is visible to host only once its packet's last
//    entry is written; host_empty compares read pointer to committed pointer.
//  - FLAGB registered, asserted when free entries < 2, so a write on the flag-update
//    cycle still fits. Write with zero free: dropped, err[0] set, counter unchanged.
//  - Strobe (SLRD/SLWR/PKTEND low) with FIFOADR 01/11: no action, err[2] set.
//  - SLRD and SLWR both low: address decides; the strobe not matching FIFOADR is ignored.
//  - host_wr and SLRD same cycle on EP2: both occur; occupancy unchanged.
//  - Pointers wrap modulo 2^AW using AW+1-bit pointers; full = MSB differ, rest equal.
//  - RESET mid-packet discards uncommitted EP6 words and all buffered data.
// STRUCTURE
//  - Shared package fx2_pkg: FIFOADR codes EP2/EP4/EP6/EP8, word width 16, err bit indices.
//  - One sub-module fx2_model_fifo (parameterized width/depth FWFT sync FIFO with
//    separate commit pointer input); instantiated for EP2 (commit=write ptr) and EP6.
//  - Top holds strobe decode, word counter, staging register, flag registers, error bits.
// TESTING
//  - host_wr 4 words 0x1111..0x4444; master SLRD x4 at EP2 -> fifo_dout 0x1111..0x4444,
//    FLAGC=0 one cycle after 4th pop, err=0.
//  - SLWR 256 words 0..255 at EP6 -> host_empty falls after 256th; word 255 has last=1;
//    host reads 256 entries in order.
//  - SLWR 3 words then PKTEND -> 3 entries, 3rd last=1; PKTEND alone next -> one entry
//    zlp=1,last=1,data=0.
//  - Fill EP6 to 511 entries without host_rd -> FLAGB=0; two more SLWR -> one stored,
//    one dropped, err=3'b001.
//  - SLRD at EP2 when empty, then SLWR with FIFOADR=01 -> err=3'b110, no state change.
//  - RESET after 10 uncommitted EP6 words -> host_empty=1, FLAGB=1, counter 0, err=0.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared constants and types for the FX2 slave-FIFO model: endpoint codes,
// word width, sticky error bit positions and the EP6 buffer entry layout.
package fx2_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    EP2 = 2'b00,
    EP4 = 2'b01,
    EP6 = 2'b10,
    EP8 = 2'b11
  } fifoadr_e;

  localparam int ERR_OVER  = 0;
  localparam int ERR_UNDER = 1;
  localparam int ERR_ADDR  = 2;

  typedef struct packed {
    logic              last;
    logic              zlp;
    logic [WORD_W-1:0] data;
  } ep6_entry_t;

  localparam int EP6_W = $bits(ep6_entry_t);

endpackage

// File: rtl/fx2_model_fifo.sv
// First-word-fall-through synchronous FIFO whose empty test uses an external
// commit pointer, so entries only become readable once the owner publishes them.
module fx2_model_fifo #(
  parameter int W  = 16,
  parameter int AW = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  input  logic [AW:0]   i_commit_ptr,
  output logic [W-1:0]  o_head,
  output logic [AW:0]   o_wr_ptr,
  output logic [AW:0]   o_count,
  output logic          o_empty
);

  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_full;
  logic         w_push_ok;
  logic         w_pop_ok;

  // AW+1-bit pointers: equal low bits with differing MSB means a full wrap.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_rd_ptr == i_commit_ptr);
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign o_wr_ptr = r_wr_ptr;
  assign o_count  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/fx2_slave_fifo_model.sv
// FX2 slave-FIFO device model: EP2 host->FPGA buffer read via SLRD, EP6
// FPGA->host buffer written via SLWR and packetized on size or PKTEND.
module fx2_slave_fifo_model
  import fx2_pkg::*;
#(
  parameter int OUT_AW    = 9,
  parameter int IN_AW     = 9,
  parameter int PKT_WORDS = 256
) (
  input  logic              IFCLK,
  input  logic              RESET,
  input  logic [1:0]        FIFOADR,
  input  logic              SLOE,
  input  logic              SLRD,
  input  logic              SLWR,
  input  logic              PKTEND,
  input  logic [WORD_W-1:0] fifo_din,
  output logic [WORD_W-1:0] fifo_dout,
  output logic              fifo_doe,
  output logic              FLAGB,
  output logic              FLAGC,
  input  logic [WORD_W-1:0] host_din,
  input  logic              host_wr,
  output logic              host_full,
  output logic [WORD_W-1:0] host_dout,
  output logic              host_last,
  output logic              host_zlp,
  output logic              host_empty,
  input  logic              host_rd,
  output logic [2:0]        err
);

  localparam int                 CNT_W     = $clog2(PKT_WORDS + 1);
  localparam logic [CNT_W-1:0]   CNT_LIM   = CNT_W'(PKT_WORDS);
  localparam logic [OUT_AW:0]    OUT_DEPTH = {1'b1, {OUT_AW{1'b0}}};
  localparam logic [IN_AW:0]     IN_DEPTH  = {1'b1, {IN_AW{1'b0}}};
  localparam logic [IN_AW:0]     IN_ALMOST = IN_DEPTH - 1'b1;

  fifoadr_e           w_adr;
  logic               w_rd_act;
  logic               w_wr_act;
  logic               w_pe_act;
  logic               w_bad_adr;
  logic               w_udf;
  logic               w_ep2_pop;

  logic [WORD_W-1:0]  w_ep2_head;
  logic [OUT_AW:0]    w_ep2_wr_ptr;
  logic [OUT_AW:0]    w_ep2_count;
  logic               w_ep2_empty;

  ep6_entry_t         w_ep6_head;
  logic [IN_AW:0]     w_ep6_wr_ptr;
  logic [IN_AW:0]     w_ep6_count;
  logic               w_ep6_empty;
  logic [IN_AW:0]     w_in_occ;
  logic               w_in_full;
  logic               w_in_low;

  logic               w_wr_ok;
  logic               w_pe_alone;
  logic               w_zlp_req;
  logic               w_zlp_ok;
  logic               w_ovf;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_new_vld;
  ep6_entry_t         w_new;
  logic               w_flush;
  logic               w_stage_vld_n;
  ep6_entry_t         w_stage_n;
  logic [CNT_W-1:0]   w_cnt_n;
  logic [2:0]         w_err_set;

  logic               r_stage_vld;
  ep6_entry_t         r_stage;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [IN_AW:0]     r_commit;
  logic               r_flagb;
  logic               r_flagc;
  logic [WORD_W-1:0]  r_dout_hold;
  logic [2:0]         r_err;

  assign w_adr     = fifoadr_e'(FIFOADR);
  assign w_rd_act  = !SLRD && (w_adr == EP2);
  assign w_wr_act  = !SLWR && (w_adr == EP6);
  assign w_pe_act  = !PKTEND && (w_adr == EP6);
  assign w_bad_adr = (!SLRD || !SLWR || !PKTEND) && ((w_adr == EP4) || (w_adr == EP8));
  assign w_udf     = w_rd_act && w_ep2_empty;
  assign w_ep2_pop = w_rd_act && !w_ep2_empty;

  fx2_model_fifo #(.W(WORD_W), .AW(OUT_AW)) u_ep2 (
    .i_clk        (IFCLK),
    .i_rst        (RESET),
    .i_push       (host_wr),
    .i_din        (host_din),
    .i_pop        (w_rd_act),
    .i_commit_ptr (w_ep2_wr_ptr),
    .o_head       (w_ep2_head),
    .o_wr_ptr     (w_ep2_wr_ptr),
    .o_count      (w_ep2_count),
    .o_empty      (w_ep2_empty)
  );

  fx2_model_fifo #(.W(EP6_W), .AW(IN_AW)) u_ep6 (
    .i_clk        (IFCLK),
    .i_rst        (RESET),
    .i_push       (w_flush),
    .i_din        (r_stage),
    .i_pop        (host_rd),
    .i_commit_ptr (r_commit),
    .o_head       (w_ep6_head),
    .o_wr_ptr     (w_ep6_wr_ptr),
    .o_count      (w_ep6_count),
    .o_empty      (w_ep6_empty)
  );

  // The staging entry counts against EP6 capacity, so a flush always finds room.
  assign w_in_occ  = w_ep6_count + (IN_AW+1)'(r_stage_vld);
  assign w_in_full = (w_in_occ == IN_DEPTH);
  assign w_in_low  = (w_in_occ >= IN_ALMOST);

  // Newest EP6 word waits in the staging entry so PKTEND can mark it last
  // before it reaches RAM; a last-marked entry drains on the following edge.
  always_comb begin
    w_wr_ok    = w_wr_act && !w_in_full;
    w_pe_alone = w_pe_act && !w_wr_ok;
    w_zlp_req  = w_pe_alone && (r_word_cnt == '0);
    w_zlp_ok   = w_zlp_req && !w_in_full;
    w_ovf      = (w_wr_act || w_zlp_req) && w_in_full;
    w_cnt_inc  = r_word_cnt + 1'b1;
    w_new_vld  = w_wr_ok || w_zlp_ok;
    w_new      = '{last: 1'b1, zlp: 1'b1, data: '0};
    if (w_wr_ok)
      w_new = '{last: (w_pe_act || (w_cnt_inc == CNT_LIM)), zlp: 1'b0, data: fifo_din};
    w_flush       = r_stage_vld && (r_stage.last || w_new_vld);
    w_stage_vld_n = r_stage_vld && !w_flush;
    w_stage_n     = r_stage;
    w_cnt_n       = r_word_cnt;
    if (w_new_vld) begin
      w_stage_vld_n = 1'b1;
      w_stage_n     = w_new;
    end else if (w_pe_alone && (r_word_cnt != '0)) begin
      w_stage_n.last = 1'b1;
    end
    if (w_wr_ok)         w_cnt_n = w_new.last ? '0 : w_cnt_inc;
    else if (w_pe_alone) w_cnt_n = '0;
    w_err_set           = '0;
    w_err_set[ERR_OVER]  = w_ovf;
    w_err_set[ERR_UNDER] = w_udf;
    w_err_set[ERR_ADDR]  = w_bad_adr;
  end

  always_ff @(posedge IFCLK or posedge RESET) begin
    if (RESET) begin
      r_stage_vld <= 1'b0;
      r_stage     <= '0;
      r_word_cnt  <= '0;
      r_commit    <= '0;
      r_flagb     <= 1'b1;
      r_flagc     <= 1'b0;
      r_dout_hold <= '0;
      r_err       <= '0;
    end else begin
      r_stage_vld <= w_stage_vld_n;
      r_stage     <= w_stage_n;
      r_word_cnt  <= w_cnt_n;
      if (w_flush && r_stage.last) r_commit <= w_ep6_wr_ptr + 1'b1;
      r_flagb     <= !w_in_low;
      r_flagc     <= !w_ep2_empty;
      if (w_ep2_pop) r_dout_hold <= w_ep2_head;
      r_err       <= r_err | w_err_set;
    end
  end

  assign fifo_dout  = w_ep2_empty ? r_dout_hold : w_ep2_head;
  assign fifo_doe   = !SLOE && (w_adr == EP2);
  assign FLAGB      = r_flagb;
  assign FLAGC      = r_flagc;
  assign host_full  = (w_ep2_count == OUT_DEPTH);
  assign host_empty = w_ep6_empty;
  assign host_dout  = w_ep6_empty ? '0 : w_ep6_head.data;
  assign host_last  = !w_ep6_empty && w_ep6_head.last;
  assign host_zlp   = !w_ep6_empty && w_ep6_head.zlp;
  assign err        = r_err;

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Directed bench for fx2_slave_fifo_model: EP2 reads, EP6 packetizing,
// flag thresholds, sticky errors and mid-packet reset.
module tb_fx2_slave_fifo_model;

  logic        IFCLK = 1'b0;
  logic        RESET;
  logic [1:0]  FIFOADR;
  logic        SLOE, SLRD, SLWR, PKTEND;
  logic [15:0] fifo_din, fifo_dout;
  logic        fifo_doe, FLAGB, FLAGC;
  logic [15:0] host_din, host_dout;
  logic        host_wr, host_full, host_last, host_zlp, host_empty, host_rd;
  logic [2:0]  err;

  int n_cmp = 0;
  int n_err = 0;

  fx2_slave_fifo_model dut (
    .IFCLK(IFCLK), .RESET(RESET), .FIFOADR(FIFOADR), .SLOE(SLOE),
    .SLRD(SLRD), .SLWR(SLWR), .PKTEND(PKTEND), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_doe(fifo_doe), .FLAGB(FLAGB), .FLAGC(FLAGC),
    .host_din(host_din), .host_wr(host_wr), .host_full(host_full),
    .host_dout(host_dout), .host_last(host_last), .host_zlp(host_zlp),
    .host_empty(host_empty), .host_rd(host_rd), .err(err)
  );

  always #5 IFCLK = ~IFCLK;

  task automatic tick();
    @(posedge IFCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic last, input logic zlp, input logic [15:0] d);
    return {14'd0, last, zlp, d};
  endfunction

  logic [15:0] exp_d;
  logic        exp_l;

  initial begin
    RESET = 1'b1; FIFOADR = 2'b00; SLOE = 1'b1; SLRD = 1'b1; SLWR = 1'b1;
    PKTEND = 1'b1; fifo_din = '0; host_din = '0; host_wr = 1'b0; host_rd = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    tick();

    chk("rst_flagb", 32'(FLAGB), 32'd1);
    chk("rst_flagc", 32'(FLAGC), 32'd0);
    chk("rst_host_full", 32'(host_full), 32'd0);
    chk("rst_host_empty", 32'(host_empty), 32'd1);
    chk("rst_host_last", 32'(host_last), 32'd0);
    chk("rst_host_zlp", 32'(host_zlp), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_fifo_dout", 32'(fifo_dout), 32'd0);
    chk("rst_doe_off", 32'(fifo_doe), 32'd0);
    SLOE = 1'b0;
    #1;
    chk("doe_on", 32'(fifo_doe), 32'd1);

    // EP2: host fills four words, master pops them
    for (int i = 1; i <= 4; i++) begin
      host_din = 16'(i * 16'h1111);
      host_wr  = 1'b1;
      tick();
    end
    host_wr = 1'b0;
    chk("ep2_flagc_ne", 32'(FLAGC), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ep2_dout", 32'(fifo_dout), 32'(i * 16'h1111));
      SLRD = 1'b0;
      tick();
    end
    SLRD = 1'b1;
    chk("ep2_flagc_stale", 32'(FLAGC), 32'd1);
    tick();
    chk("ep2_flagc_empty", 32'(FLAGC), 32'd0);
    chk("ep2_dout_hold", 32'(fifo_dout), 32'h4444);
    chk("ep2_err", 32'(err), 32'd0);

    // EP2: host_wr and SLRD in the same cycle
    host_din = 16'h5555; host_wr = 1'b1;
    tick();
    host_din = 16'h6666; SLRD = 1'b0;
    tick();
    host_wr = 1'b0;
    chk("ep2_simul_head", 32'(fifo_dout), 32'h6666);
    tick();
    SLRD = 1'b1;
    chk("ep2_simul_hold", 32'(fifo_dout), 32'h6666);
    tick();
    chk("ep2_simul_flagc", 32'(FLAGC), 32'd0);
    chk("ep2_simul_err", 32'(err), 32'd0);

    // EP6: one full 256-word packet
    FIFOADR = 2'b10;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("ep6_uncommitted", 32'(host_empty), 32'd1);
      fifo_din = 16'(i);
      SLWR = 1'b0;
      tick();
    end
    SLWR = 1'b1;
    tick();
    chk("ep6_committed", 32'(host_empty), 32'd0);
    host_rd = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk("ep6_pkt256", 32'({host_last, host_zlp, host_dout}), ent(i == 255, 1'b0, 16'(i)));
      tick();
    end
    host_rd = 1'b0;
    chk("ep6_drained", 32'(host_empty), 32'd1);

    // EP6: short packet via PKTEND, then a ZLP
    for (int i = 1; i <= 3; i++) begin
      fifo_din = 16'(16'hA000 + i);
      SLWR = 1'b0;
      tick();
    end
    SLWR = 1'b1; PKTEND = 1'b0;
    tick();
    PKTEND = 1'b1;
    tick();
    PKTEND = 1'b0;
    tick();
    PKTEND = 1'b1;
    tick(); tick();
    host_rd = 1'b1;
    chk("short_w1", 32'({host_last, host_zlp, host_dout}), ent(1'b0, 1'b0, 16'hA001));
    tick();
    chk("short_w2", 32'({host_last, host_zlp, host_dout}), ent(1'b0, 1'b0, 16'hA002));
    tick();
    chk("short_w3", 32'({host_last, host_zlp, host_dout}), ent(1'b1, 1'b0, 16'hA003));
    tick();
    chk("zlp", 32'({host_last, host_zlp, host_dout}), ent(1'b1, 1'b1, 16'h0000));
    tick();
    host_rd = 1'b0;
    chk("zlp_drained", 32'(host_empty), 32'd1);

    // EP6: SLWR and PKTEND together -> single last word, no ZLP
    fifo_din = 16'hB00B; SLWR = 1'b0; PKTEND = 1'b0;
    tick();
    SLWR = 1'b1; PKTEND = 1'b1;
    tick(); tick();
    chk("wr_pe_word", 32'({host_last, host_zlp, host_dout}), ent(1'b1, 1'b0, 16'hB00B));
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    chk("wr_pe_single", 32'(host_empty), 32'd1);

    // Underflow at EP2 and a strobe on an unsupported address
    FIFOADR = 2'b00; SLRD = 1'b0;
    tick();
    SLRD = 1'b1; FIFOADR = 2'b01; SLWR = 1'b0;
    tick();
    SLWR = 1'b1; FIFOADR = 2'b10;
    tick();
    chk("err_udf_addr", 32'(err), 32'b110);
    chk("err_host_empty", 32'(host_empty), 32'd1);
    chk("err_flagb", 32'(FLAGB), 32'd1);
    chk("err_flagc", 32'(FLAGC), 32'd0);
    chk("err_dout_hold", 32'(fifo_dout), 32'h6666);

    // Reset in the middle of an uncommitted EP6 packet
    for (int i = 0; i < 10; i++) begin
      fifo_din = 16'(16'hC000 + i);
      SLWR = 1'b0;
      tick();
    end
    SLWR = 1'b1; RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick(); tick();
    chk("mid_rst_empty", 32'(host_empty), 32'd1);
    chk("mid_rst_flagb", 32'(FLAGB), 32'd1);
    chk("mid_rst_err", 32'(err), 32'd0);
    PKTEND = 1'b0;
    tick();
    PKTEND = 1'b1;
    tick(); tick();
    chk("mid_rst_cnt0_zlp", 32'({host_last, host_zlp, host_dout}), ent(1'b1, 1'b1, 16'h0000));
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    chk("mid_rst_zlp_pop", 32'(host_empty), 32'd1);

    // EP6 fill to capacity: FLAGB threshold and overflow drop
    for (int i = 0; i < 511; i++) begin
      fifo_din = 16'(i);
      SLWR = 1'b0;
      tick();
    end
    chk("fill_flagb_510", 32'(FLAGB), 32'd1);
    SLWR = 1'b1;
    tick();
    chk("fill_flagb_511", 32'(FLAGB), 32'd0);
    fifo_din = 16'h7001; SLWR = 1'b0;
    tick();
    fifo_din = 16'h7002;
    tick();
    SLWR = 1'b1;
    tick();
    chk("fill_err_ovf", 32'(err), 32'b001);
    chk("fill_flagb_full", 32'(FLAGB), 32'd0);
    host_rd = 1'b1;
    for (int i = 0; i < 512; i++) begin
      exp_d = (i < 511) ? 16'(i) : 16'h7001;
      exp_l = (i == 255) || (i == 511);
      chk("fill_entry", 32'({host_last, host_zlp, host_dout}), ent(exp_l, 1'b0, exp_d));
      tick();
    end
    host_rd = 1'b0;
    chk("fill_drained", 32'(host_empty), 32'd1);
    tick();
    chk("fill_flagb_free", 32'(FLAGB), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
